// File: rtl/pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control_unit
// Purpose  : MIPS ID-stage control. Decodes opcode/funct, registers the ID/EX
//            control bundle, and owns every front-end stall/flush decision:
//            load-use hazard stall, taken-branch flush and a fixed-latency
//            multiply stall FSM.
// Ports    : clock_in, reset_in          - clock, async active-high reset
//            opcode_in, funct_in         - IF/ID instr[31:26], instr[5:0]
//            rs_in, rt_in                - IF/ID source specifiers
//            idex_memRead_in, idex_rt_in - load currently in EX and its rt
//            branch_taken_in             - EX resolved a taken beq/bne
//            aluOp_out .. mul_out        - registered ID/EX control bundle
//            pc_write_out, ifid_write_out, ifid_flush_out - combinational
//            busy_out                    - registered, mul FSM in BUSY
// Revision : 1.0 - initial release
// ============================================================================
module pipe_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 4,
    parameter int ENABLE_MUL  = 1
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [5:0]            opcode_in,
    input  logic [5:0]            funct_in,
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [REG_ADDR_W-1:0] rt_in,
    input  logic                  idex_memRead_in,
    input  logic [REG_ADDR_W-1:0] idex_rt_in,
    input  logic                  branch_taken_in,
    output logic [2:0]            aluOp_out,
    output logic                  branch_out,
    output logic                  bne_out,
    output logic                  jump_out,
    output logic                  memtoReg_out,
    output logic                  memRead_out,
    output logic                  memWrite_out,
    output logic                  aluSrc_out,
    output logic                  regWrite_out,
    output logic                  regDst_out,
    output logic                  mul_out,
    output logic                  pc_write_out,
    output logic                  ifid_write_out,
    output logic                  ifid_flush_out,
    output logic                  busy_out
);

    // Opcode / funct encodings
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_mul   = 6'b011100;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_fn_mul   = 6'b000010;

    // ALU operation encodings
    localparam logic [2:0] c_alu_add   = 3'b000;
    localparam logic [2:0] c_alu_sub   = 3'b001;
    localparam logic [2:0] c_alu_funct = 3'b010;
    localparam logic [2:0] c_alu_and   = 3'b011;
    localparam logic [2:0] c_alu_or    = 3'b100;
    localparam logic [2:0] c_alu_slt   = 3'b101;
    localparam logic [2:0] c_alu_lui   = 3'b110;

    // Mul FSM
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_busy = 1'b1;

    localparam int                 c_cnt_w    = $clog2(MUL_LATENCY) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MUL_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    // Decoded (next) bundle
    logic [2:0] w_alu_op;
    logic       w_branch, w_bne, w_jump, w_memtoreg, w_memread, w_memwrite;
    logic       w_alusrc, w_regwrite, w_regdst, w_mul;
    logic       w_rt_is_src;
    logic       w_hz;
    logic       w_bubble;

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    always_comb begin
        w_alu_op    = c_alu_add;
        w_branch    = 1'b0;
        w_bne       = 1'b0;
        w_jump      = 1'b0;
        w_memtoreg  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_alusrc    = 1'b0;
        w_regwrite  = 1'b0;
        w_regdst    = 1'b0;
        w_mul       = 1'b0;
        w_rt_is_src = 1'b0;
        case (opcode_in)
            c_op_rtype: begin
                w_alu_op    = c_alu_funct;
                w_regwrite  = 1'b1;
                w_regdst    = 1'b1;
                w_rt_is_src = 1'b1;
            end
            c_op_addiu: begin
                w_alu_op   = c_alu_add;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_andi: begin
                w_alu_op   = c_alu_and;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_ori: begin
                w_alu_op   = c_alu_or;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_slti: begin
                w_alu_op   = c_alu_slt;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_lui: begin
                w_alu_op   = c_alu_lui;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_lw: begin
                w_alu_op   = c_alu_add;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_op_sw: begin
                w_alu_op    = c_alu_add;
                w_memwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_rt_is_src = 1'b1;
            end
            c_op_beq: begin
                w_alu_op    = c_alu_sub;
                w_branch    = 1'b1;
                w_rt_is_src = 1'b1;
            end
            c_op_bne: begin
                w_alu_op    = c_alu_sub;
                w_branch    = 1'b1;
                w_bne       = 1'b1;
                w_rt_is_src = 1'b1;
            end
            c_op_j: begin
                w_jump = 1'b1;
            end
            c_op_mul: begin
                // Only the exact mul funct decodes; other SPECIAL2 ops are NOPs.
                if (ENABLE_MUL != 0 && funct_in == c_fn_mul) begin
                    w_alu_op    = c_alu_funct;
                    w_mul       = 1'b1;
                    w_regwrite  = 1'b1;
                    w_regdst    = 1'b1;
                    w_rt_is_src = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Load-use: $0 never carries a hazard; rt only counts when it is read.
    assign w_hz = idex_memRead_in && (idex_rt_in != '0) &&
                  ((idex_rt_in == rs_in) || (w_rt_is_src && (idex_rt_in == rt_in)));

    assign w_bubble = branch_taken_in || (r_state == c_busy) || w_hz;

    always_comb begin
        pc_write_out   = 1'b0;
        ifid_write_out = 1'b0;
        ifid_flush_out = 1'b0;
        if (reset_in) begin
            pc_write_out   = 1'b0;
            ifid_write_out = 1'b0;
            ifid_flush_out = 1'b0;
        end else if (branch_taken_in) begin
            // The wrong-path instruction in IF/ID is cleared; fetch continues.
            pc_write_out   = 1'b1;
            ifid_write_out = 1'b1;
            ifid_flush_out = 1'b1;
        end else if (r_state == c_busy || w_hz) begin
            pc_write_out   = 1'b0;
            ifid_write_out = 1'b0;
        end else begin
            pc_write_out   = 1'b1;
            ifid_write_out = 1'b1;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            aluOp_out    <= c_alu_add;
            branch_out   <= 1'b0;
            bne_out      <= 1'b0;
            jump_out     <= 1'b0;
            memtoReg_out <= 1'b0;
            memRead_out  <= 1'b0;
            memWrite_out <= 1'b0;
            aluSrc_out   <= 1'b0;
            regWrite_out <= 1'b0;
            regDst_out   <= 1'b0;
            mul_out      <= 1'b0;
            r_state      <= c_idle;
            r_cnt        <= c_cnt_zero;
        end else begin
            if (w_bubble) begin
                aluOp_out    <= c_alu_add;
                branch_out   <= 1'b0;
                bne_out      <= 1'b0;
                jump_out     <= 1'b0;
                memtoReg_out <= 1'b0;
                memRead_out  <= 1'b0;
                memWrite_out <= 1'b0;
                aluSrc_out   <= 1'b0;
                regWrite_out <= 1'b0;
                regDst_out   <= 1'b0;
                mul_out      <= 1'b0;
            end else begin
                aluOp_out    <= w_alu_op;
                branch_out   <= w_branch;
                bne_out      <= w_bne;
                jump_out     <= w_jump;
                memtoReg_out <= w_memtoreg;
                memRead_out  <= w_memread;
                memWrite_out <= w_memwrite;
                aluSrc_out   <= w_alusrc;
                regWrite_out <= w_regwrite;
                regDst_out   <= w_regdst;
                mul_out      <= w_mul;
            end

            case (r_state)
                c_idle: begin
                    // A mul is issued only when its decoded bundle is loaded.
                    if (!w_bubble && w_mul && MUL_LATENCY > 1) begin
                        r_state <= c_busy;
                        r_cnt   <= c_cnt_load;
                    end
                end
                c_busy: begin
                    // Leaving at 1 gives exactly MUL_LATENCY-1 stall cycles.
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_idle;
                        r_cnt   <= c_cnt_zero;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_cnt   <= c_cnt_zero;
                end
            endcase
        end
    end

    assign busy_out = (r_state == c_busy);

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control_unit
// Purpose  : Self-checking bench. Three instances share one stimulus stream:
//            u0 default (MUL_LATENCY=4), u1 MUL_LATENCY=1, u2 ENABLE_MUL=0.
//            A behavioural model predicts every output each cycle; a few
//            hand-computed literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opc, fn;
    logic [4:0] rs, rt, irt;
    logic       mr, br;

    logic [2:0] alu_op_v [3];
    logic [2:0] branch_v, bne_v, jump_v, memtoreg_v, memread_v, memwrite_v;
    logic [2:0] alusrc_v, regwrite_v, regdst_v, mul_v;
    logic [2:0] pc_write_v, ifid_write_v, ifid_flush_v, busy_v;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipe_control_unit #(.REG_ADDR_W(5), .MUL_LATENCY(4), .ENABLE_MUL(1)) u0 (
        .clock_in(clk), .reset_in(rst), .opcode_in(opc), .funct_in(fn),
        .rs_in(rs), .rt_in(rt), .idex_memRead_in(mr), .idex_rt_in(irt),
        .branch_taken_in(br), .aluOp_out(alu_op_v[0]), .branch_out(branch_v[0]),
        .bne_out(bne_v[0]), .jump_out(jump_v[0]), .memtoReg_out(memtoreg_v[0]),
        .memRead_out(memread_v[0]), .memWrite_out(memwrite_v[0]),
        .aluSrc_out(alusrc_v[0]), .regWrite_out(regwrite_v[0]),
        .regDst_out(regdst_v[0]), .mul_out(mul_v[0]), .pc_write_out(pc_write_v[0]),
        .ifid_write_out(ifid_write_v[0]), .ifid_flush_out(ifid_flush_v[0]),
        .busy_out(busy_v[0]));

    pipe_control_unit #(.REG_ADDR_W(5), .MUL_LATENCY(1), .ENABLE_MUL(1)) u1 (
        .clock_in(clk), .reset_in(rst), .opcode_in(opc), .funct_in(fn),
        .rs_in(rs), .rt_in(rt), .idex_memRead_in(mr), .idex_rt_in(irt),
        .branch_taken_in(br), .aluOp_out(alu_op_v[1]), .branch_out(branch_v[1]),
        .bne_out(bne_v[1]), .jump_out(jump_v[1]), .memtoReg_out(memtoreg_v[1]),
        .memRead_out(memread_v[1]), .memWrite_out(memwrite_v[1]),
        .aluSrc_out(alusrc_v[1]), .regWrite_out(regwrite_v[1]),
        .regDst_out(regdst_v[1]), .mul_out(mul_v[1]), .pc_write_out(pc_write_v[1]),
        .ifid_write_out(ifid_write_v[1]), .ifid_flush_out(ifid_flush_v[1]),
        .busy_out(busy_v[1]));

    pipe_control_unit #(.REG_ADDR_W(5), .MUL_LATENCY(4), .ENABLE_MUL(0)) u2 (
        .clock_in(clk), .reset_in(rst), .opcode_in(opc), .funct_in(fn),
        .rs_in(rs), .rt_in(rt), .idex_memRead_in(mr), .idex_rt_in(irt),
        .branch_taken_in(br), .aluOp_out(alu_op_v[2]), .branch_out(branch_v[2]),
        .bne_out(bne_v[2]), .jump_out(jump_v[2]), .memtoReg_out(memtoreg_v[2]),
        .memRead_out(memread_v[2]), .memWrite_out(memwrite_v[2]),
        .aluSrc_out(alusrc_v[2]), .regWrite_out(regwrite_v[2]),
        .regDst_out(regdst_v[2]), .mul_out(mul_v[2]), .pc_write_out(pc_write_v[2]),
        .ifid_write_out(ifid_write_v[2]), .ifid_flush_out(ifid_flush_v[2]),
        .busy_out(busy_v[2]));

    // ---------------- behavioural model ----------------
    // Bundle layout: {aluOp[2:0], branch, bne, jump, memtoReg, memRead,
    //                 memWrite, aluSrc, regWrite, regDst, mul}
    int          lat [3] = '{4, 1, 4};
    int          en  [3] = '{1, 1, 0};
    int          left[3] = '{0, 0, 0};     // remaining mul stall cycles
    logic [12:0] exp_b[3] = '{13'd0, 13'd0, 13'd0};

    function automatic logic [12:0] decode(logic [5:0] o, logic [5:0] f, int e);
        case (o)
            6'b000000: return {3'b010, 10'b0000000110};
            6'b001001: return {3'b000, 10'b0000001100};
            6'b001100: return {3'b011, 10'b0000001100};
            6'b001101: return {3'b100, 10'b0000001100};
            6'b001010: return {3'b101, 10'b0000001100};
            6'b001111: return {3'b110, 10'b0000001100};
            6'b100011: return {3'b000, 10'b0001101100};
            6'b101011: return {3'b000, 10'b0000011000};
            6'b000100: return {3'b001, 10'b1000000000};
            6'b000101: return {3'b001, 10'b1100000000};
            6'b000010: return {3'b000, 10'b0010000000};
            6'b011100: return (e != 0 && f == 6'b000010) ? {3'b010, 10'b0000000111} : 13'd0;
            default:   return 13'd0;
        endcase
    endfunction

    function automatic bit load_use(int e);
        bit reads_rt;
        reads_rt = (opc == 6'b000000) || (opc == 6'b000100) || (opc == 6'b000101) ||
                   (opc == 6'b101011) || (e != 0 && opc == 6'b011100 && fn == 6'b000010);
        if (!mr || irt == 5'd0) return 1'b0;
        return (irt == rs) || (reads_rt && irt == rt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                left[k]  = 0;
                exp_b[k] = 13'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [12:0] d;
                bit          stall;
                d        = decode(opc, fn, en[k]);
                stall    = br || (left[k] > 0) || load_use(en[k]);
                exp_b[k] = stall ? 13'd0 : d;
                if (left[k] > 0)                    left[k] = left[k] - 1;
                else if (!stall && d[0] && lat[k] > 1) left[k] = lat[k] - 1;
            end
        end
    end

    function automatic logic [12:0] act_bundle(int k);
        return {alu_op_v[k], branch_v[k], bne_v[k], jump_v[k], memtoreg_v[k],
                memread_v[k], memwrite_v[k], alusrc_v[k], regwrite_v[k],
                regdst_v[k], mul_v[k]};
    endfunction

    task automatic chk(string name, int k, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s u%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [2:0] ectl;   // {pc_write, ifid_write, ifid_flush}
            if (rst)                                    ectl = 3'b000;
            else if (br)                                ectl = 3'b111;
            else if (left[k] > 0 || load_use(en[k]))    ectl = 3'b000;
            else                                        ectl = 3'b110;
            chk("bundle", k, 16'(act_bundle(k)), 16'(exp_b[k]));
            chk("ctl", k, 16'({pc_write_v[k], ifid_write_v[k], ifid_flush_v[k]}), 16'(ectl));
            chk("busy", k, 16'(busy_v[k]), 16'(left[k] > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(logic [5:0] o, logic [5:0] f, logic [4:0] s, logic [4:0] t,
                         logic m, logic [4:0] it, logic b);
        opc = o; fn = f; rs = s; rt = t; mr = m; irt = it; br = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] sweep [12] = '{6'b000000, 6'b001001, 6'b001100, 6'b001101, 6'b001010,
                               6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                               6'b000010, 6'b110011};

    initial begin
        opc = 6'b111111; fn = 6'd0; rs = 5'd0; rt = 5'd0; mr = 1'b0; irt = 5'd0; br = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_pc", 0, 16'(pc_write_v[0]), 16'd0);
        chk("lit_rst_ifid", 0, 16'(ifid_write_v[0]), 16'd0);
        rst = 1'b0;

        // addiu, rt=5 as destination
        tick();
        drive(6'b001001, 6'd0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0);
        chk("lit_pc_normal", 0, 16'(pc_write_v[0]), 16'd1);
        tick();
        chk("lit_addiu", 0, 16'(act_bundle(0)), 16'h000C);

        // load-use: lw r5 in EX, add rs=5 in ID
        drive(6'b000000, 6'b100001, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
        chk("lit_hz_pc", 0, 16'({pc_write_v[0], ifid_write_v[0]}), 16'd0);
        tick();
        chk("lit_hz_bubble", 0, 16'(act_bundle(0)), 16'd0);
        // same with idex_rt=0: no stall
        drive(6'b000000, 6'b100001, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        chk("lit_r0_pc", 0, 16'(pc_write_v[0]), 16'd1);
        tick();
        chk("lit_rtype", 0, 16'(act_bundle(0)), 16'h0806);
        // addiu rt=5 while r5 loads: rt is a destination, no stall
        drive(6'b001001, 6'd0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0);
        chk("lit_addiu_rt", 0, 16'(pc_write_v[0]), 16'd1);
        tick();
        // branch taken together with hazard
        drive(6'b000000, 6'b100001, 5'd5, 5'd6, 1'b1, 5'd5, 1'b1);
        chk("lit_br_ctl", 0, 16'({pc_write_v[0], ifid_flush_v[0]}), 16'd3);
        tick();
        chk("lit_br_bubble", 0, 16'(act_bundle(0)), 16'd0);
        // bne
        drive(6'b000101, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lit_bne", 0, 16'({alu_op_v[0], branch_v[0], bne_v[0]}), 16'b00111);
        // sw reads rt -> stall; ori rt is destination -> no stall
        drive(6'b101011, 6'd0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        chk("lit_sw_hz", 0, 16'(pc_write_v[0]), 16'd0);
        tick();
        drive(6'b001101, 6'd0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
        chk("lit_ori_nohz", 0, 16'(pc_write_v[0]), 16'd1);
        tick();

        // mul issue
        drive(6'b011100, 6'b000010, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lit_mul_u0", 0, 16'({mul_v[0], busy_v[0]}), 16'd3);
        chk("lit_mul_u1", 1, 16'({mul_v[1], busy_v[1]}), 16'd2);
        chk("lit_mul_u2", 2, 16'(act_bundle(2)), 16'd0);
        drive(6'b001001, 6'd0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("lit_mul_stall", 0, 16'({busy_v[0], pc_write_v[0]}), 16'd2);
            tick();
        end
        chk("lit_mul_done", 0, 16'({busy_v[0], pc_write_v[0]}), 16'd1);
        tick();
        chk("lit_held_issue", 0, 16'(act_bundle(0)), 16'h000C);

        // reset in the middle of BUSY (count = 2)
        drive(6'b011100, 6'b000010, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        tick();
        drive(6'b001001, 6'd0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("lit_mrst_busy", 0, 16'(busy_v[0]), 16'd0);
        chk("lit_mrst_bundle", 0, 16'(act_bundle(0)), 16'd0);
        chk("lit_mrst_ctl", 0, 16'({pc_write_v[0], ifid_write_v[0], ifid_flush_v[0]}), 16'd0);
        tick();
        rst = 1'b0;
        drive(6'b001001, 6'd0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lit_post_rst", 0, 16'({alusrc_v[0], regwrite_v[0]}), 16'd3);

        // decode sweep, including an unlisted opcode and a jump
        foreach (sweep[i]) begin
            drive(sweep[i], 6'b100000, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
            tick();
        end
        drive(6'b011100, 6'b000011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);   // not mul funct
        tick();
        drive(6'b111111, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Second-generation MIPS pipeline control unit: decodes opcode/funct in ID and registers the ID/EX control bundle.
- Adds load-use hazard stall, branch-taken flush, and a fixed-latency multiply stall FSM, so one block owns all front-end stall/flush decisions.
- Sits between the IF/ID register, the register file and the ID/EX register. The EX stage supplies branch resolution and the ID/EX load information.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MUL_LATENCY, 4, EX cycles a mul occupies (>=1). 1 means no busy state.
- ENABLE_MUL, 1, 0 makes mul decode as default/NOP.

Ports:
- clock_in  input  1  rising-edge clock
- reset_in  input  1  asynchronous, active-high reset
- opcode_in  input  6  IF/ID instr[31:26]
- funct_in  input  6  IF/ID instr[5:0]
- rs_in  input  REG_ADDR_W  IF/ID rs
- rt_in  input  REG_ADDR_W  IF/ID rt
- idex_memRead_in  input  1  instruction in EX is a load
- idex_rt_in  input  REG_ADDR_W  destination rt of that load
- branch_taken_in  input  1  EX resolved a taken beq/bne
- aluOp_out  output  3  registered. 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui
- branch_out, bne_out, jump_out, memtoReg_out, memRead_out, memWrite_out, aluSrc_out, regWrite_out, regDst_out, mul_out  output  1 each  registered ID/EX controls
- pc_write_out  output  1  combinational PC enable
- ifid_write_out  output  1  combinational IF/ID enable
- ifid_flush_out  output  1  combinational IF/ID clear
- busy_out  output  1  registered, high while the mul FSM is in BUSY

Behaviour:
- Reset (asynchronous, any time, including mid-mul): all registered outputs 0, FSM IDLE, counter 0. While reset_in=1: pc_write_out=0, ifid_write_out=0, ifid_flush_out=0.
- Decode (next-bundle value):
  - R-type 000000: aluOp 010, regWrite, regDst.
  - addiu 001001: aluSrc, regWrite, aluOp 000.
  - andi 001100: aluOp 011, aluSrc, regWrite.
  - ori 001101: aluOp 100, aluSrc, regWrite.
  - slti 001010: aluOp 101, aluSrc, regWrite.
  - lui 001111: aluOp 110, aluSrc, regWrite.
  - lw 100011: memRead, memtoReg, aluSrc, regWrite, aluOp 000.
  - sw 101011: memWrite, aluSrc, aluOp 000.
  - beq 000100: branch, aluOp 001.
  - bne 000101: branch, bne, aluOp 001.
  - j 000010: jump.
  - mul 011100 with funct 000010 (ENABLE_MUL=1): mul, regWrite, regDst, aluOp 010.
  - Anything else: all zeros (NOP). All unlisted bits are 0.
- Latency: ID/EX bundle updates on the clock edge after decode, 1 cycle.
- Load-use hazard (hz):
  - Condition: idex_memRead_in=1 and idex_rt_in!=0 and the loaded register matches a source.
  - Sources: idex_rt_in==rs_in always; idex_rt_in==rt_in only for R-type, mul, beq, bne, sw.
- Priority, highest first:
  - reset.
  - branch_taken_in: ifid_flush_out=1, pc_write_out=1, next bundle = bubble (all 0). A mul in ID is discarded and not issued.
  - FSM BUSY: pc_write_out=0, ifid_write_out=0, bubble.
  - hz: pc_write_out=0, ifid_write_out=0, bubble for 1 cycle.
  - Normal: pc_write_out=1, ifid_write_out=1, decoded bundle.
- Mul FSM:
  - IDLE->BUSY when a mul is issued (decoded bundle loaded with mul_out=1) and MUL_LATENCY>1; counter loads MUL_LATENCY-1.
  - In BUSY the counter decrements each cycle. BUSY->IDLE when it reaches 1, so the stall lasts exactly MUL_LATENCY-1 cycles after issue.
  - busy_out=1 exactly while the FSM is in BUSY.
  - branch_taken_in cannot occur during BUSY, since mul is the youngest instruction in EX. It is ignored there for the bubble but still drives ifid_flush_out.
- jump_out is decoded only; PC redirect is outside this block. The IF instruction after j is not flushed here; delay-slot semantics apply.
- Counter width: $clog2(MUL_LATENCY)+1.

Test Plan:
- Reset mid-BUSY (count=2) -> all outputs 0 immediately, busy_out=0; after release, the next opcode 001001 gives aluSrc_out=1, regWrite_out=1 one cycle later.
- lw r5 in EX (idex_memRead_in=1, idex_rt_in=5) + ID add rs=5 -> pc_write_out=0, ifid_write_out=0 for 1 cycle, next bundle all 0. With idex_rt_in=0 -> no stall.
- ID addiu rt=5 (rt is a destination) with idex_rt_in=5 load -> no stall.
- branch_taken_in=1 together with a hazard -> ifid_flush_out=1, pc_write_out=1, bubble.
- mul issue, MUL_LATENCY=4 -> mul_out=1 next cycle; busy_out=1 and pc_write_out=0 for exactly 3 cycles; then the held instruction issues.
- MUL_LATENCY=1 -> no busy cycles.
- Opcode 000101 -> branch_out=1, bne_out=1, aluOp_out=001. ENABLE_MUL=0 with mul encoding -> all 0.
